// File: rtl/midi_pkg.sv
// Shared constants and types for the MIDI button front-end.
// MIDI_BTN_RELEASE_EN adds the press/release polarity bit to queued events.
package midi_pkg;

  localparam logic [3:0] MIDI_CC_STATUS = 4'hB;
  localparam logic [7:0] CC_ON          = 8'h7F;
  localparam logic [7:0] CC_OFF         = 8'h00;

  // Index field sized for the largest supported button count (8).
  localparam int IDX_W = 3;

`ifdef MIDI_BTN_RELEASE_EN
  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             polarity;  // 1 = press, 0 = release
  } btn_evt_t;
`else
  typedef struct packed {
    logic [IDX_W-1:0] index;
  } btn_evt_t;
`endif

  typedef enum logic [1:0] {IDLE, STATUS, DATA1, DATA2} ser_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stability counter and debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);

  logic             r_meta;
  logic             r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/midi_btn_event.sv
// Debounced buttons -> pending latches -> event FIFO -> 3-byte MIDI CC stream.
// Define MIDI_BTN_RELEASE_EN to also emit CC value 0x00 on button release.
module midi_btn_event
  import midi_pkg::*;
#(
  parameter int         NUM_BTN      = 4,
  parameter int         DEBOUNCE_CYC = 1_000_000,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [3:0] CHANNEL      = 4'h0,
  parameter logic [7:0] FIRST_CC     = 8'd46
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [7:0]         msg_byte,
  output logic               msg_valid,
  input  logic               msg_ready,
  output logic               msg_last,
  output logic [NUM_BTN-1:0] btn_state,
  output logic               evt_drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [NUM_BTN-1:0] w_stable;
  logic [NUM_BTN-1:0] r_state_d;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_edge;
  logic [NUM_BTN-1:0] r_pending;
  logic [NUM_BTN-1:0] w_grant;
  logic [NUM_BTN-1:0] w_clr;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               r_evt_drop;
  btn_evt_t           w_push_evt;
  btn_evt_t           r_hold;
  btn_evt_t           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  ser_state_t         r_state;
  ser_state_t         w_state_nxt;
  logic [7:0]         w_data2;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (btn_raw[g]),
      .o_stable (w_stable[g])
    );
  end

  assign btn_state = w_stable;
  assign w_rise    = w_stable & ~r_state_d;

`ifdef MIDI_BTN_RELEASE_EN
  logic [NUM_BTN-1:0] r_pol;
  logic               w_grant_pol;
  assign w_edge      = w_stable ^ r_state_d;
  assign w_push_evt  = '{index: w_grant_idx, polarity: w_grant_pol};
  assign w_data2     = r_hold.polarity ? CC_ON : CC_OFF;
`else
  assign w_edge      = w_rise;
  assign w_push_evt  = '{index: w_grant_idx};
  assign w_data2     = CC_ON;
`endif

  // Lowest index wins: scan downwards so the last match is the smallest.
  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
`ifdef MIDI_BTN_RELEASE_EN
    w_grant_pol = 1'b0;
`endif
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_grant     = '0;
        w_grant[i]  = 1'b1;
        w_grant_idx = IDX_W'(i);
`ifdef MIDI_BTN_RELEASE_EN
        w_grant_pol = r_pol[i];
`endif
      end
    end
  end

  assign w_full  = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = (|r_pending) && !w_full;
  assign w_clr   = w_push ? w_grant : '0;

  // An edge that lands while the same button's previous event is still
  // unqueued replaces it; one granted this cycle has already been saved.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_d  <= '0;
      r_pending  <= '0;
      r_evt_drop <= 1'b0;
    end else begin
      r_state_d  <= w_stable;
      r_pending  <= (r_pending & ~w_clr) | w_edge;
      r_evt_drop <= |(w_edge & r_pending & ~w_clr);
    end
  end

`ifdef MIDI_BTN_RELEASE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pol <= '0;
    else      r_pol <= (r_pol & ~w_edge) | (w_rise & w_edge);
  end
`endif

  assign evt_drop = r_evt_drop;

  // NOTE: the FIFO storage is deliberately not reset; the pointers and count
  // define validity, so the array can map onto plain RAM/registers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_evt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
      r_state  <= IDLE;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_hold   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    msg_valid   = 1'b0;
    msg_last    = 1'b0;
    msg_byte    = '0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = STATUS;
        end
      end
      STATUS: begin
        msg_valid = 1'b1;
        msg_byte  = {MIDI_CC_STATUS, CHANNEL};
        if (msg_ready) w_state_nxt = DATA1;
      end
      DATA1: begin
        msg_valid = 1'b1;
        msg_byte  = FIRST_CC + 8'(r_hold.index);
        if (msg_ready) w_state_nxt = DATA2;
      end
      DATA2: begin
        msg_valid = 1'b1;
        msg_last  = 1'b1;
        msg_byte  = w_data2;
        if (msg_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_midi_btn_event.sv
// Directed bench for midi_btn_event with DEBOUNCE_CYC=4 and FIFO_DEPTH=2.
module tb_midi_btn_event;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic [7:0] msg_byte;
  logic       msg_valid;
  logic       msg_ready;
  logic       msg_last;
  logic [3:0] btn_state;
  logic       evt_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  midi_btn_event #(
    .NUM_BTN      (4),
    .DEBOUNCE_CYC (4),
    .FIFO_DEPTH   (2),
    .CHANNEL      (4'h0),
    .FIRST_CC     (8'd46)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .msg_byte  (msg_byte),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_last  (msg_last),
    .btn_state (btn_state),
    .evt_drop  (evt_drop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (msg_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check(tag, 32'(msg_valid), 32'd1);
  endtask

  // Full message with msg_ready=1, ending on the idle cycle after DATA2.
  task automatic get_msg(input string tag, input logic [7:0] cc, input logic [7:0] val);
    wait_valid({tag, "_wait"});
    check({tag, "_status"}, 32'({msg_last, msg_byte}), 32'({1'b0, 8'hB0}));
    step();
    check({tag, "_data1"}, 32'({msg_valid, msg_last, msg_byte}), 32'({2'b10, cc}));
    step();
    check({tag, "_data2"}, 32'({msg_valid, msg_last, msg_byte}), 32'({2'b11, val}));
    step();
    check({tag, "_idle"}, 32'(msg_valid), 32'd0);
  endtask

  task automatic quiet(input string tag, input int n);
    logic ok = 1'b1;
    repeat (n) begin
      step();
      if (msg_valid !== 1'b0) ok = 1'b0;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   drops;

    rst       = 1'b0;
    btn_raw   = '0;
    msg_ready = 1'b1;
    repeat (3) step();
    check("reset_outputs", 32'({msg_valid, msg_last, msg_byte, btn_state, evt_drop}), 32'd0);
    rst = 1'b1;
    repeat (3) step();

    // Press btn 0: the first step below returns just after sampling edge 0.
    btn_raw[0] = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      step();
      if (i == 4) check("db_before_flip", 32'(btn_state[0]), 32'd0);
      if (i == 5) check("db_after_flip", 32'(btn_state[0]), 32'd1);
      if (i == 7) check("latency_edge7", 32'(msg_valid), 32'd0);
    end
    check("latency_edge8", 32'(msg_valid), 32'd1);
    get_msg("press0", 8'h2E, 8'h7F);

    btn_raw[0] = 1'b0;
`ifdef MIDI_BTN_RELEASE_EN
    get_msg("release0", 8'h2E, 8'h00);
`else
    quiet("release0_silent", 15);
`endif
    repeat (5) step();

    // Backpressure in DATA1.
    btn_raw[0] = 1'b1;
    wait_valid("bp_wait");
    check("bp_status", 32'(msg_byte), 32'h0B0);
    step();
    check("bp_data1", 32'({msg_valid, msg_byte}), 32'({1'b1, 8'h2E}));
    msg_ready = 1'b0;
    ok = 1'b1;
    repeat (10) begin
      step();
      if (msg_valid !== 1'b1 || msg_byte !== 8'h2E || msg_last !== 1'b0) ok = 1'b0;
    end
    check("bp_held_stable", 32'(ok), 32'd1);
    msg_ready = 1'b1;
    step();
    check("bp_data2", 32'({msg_valid, msg_last, msg_byte}), 32'({2'b11, 8'h7F}));
    step();
    check("bp_idle", 32'(msg_valid), 32'd0);

    // Bounce btn 1 every 2 cycles, then hold high.
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      btn_raw[1] = ~btn_raw[1];
      repeat (2) begin
        step();
        if (msg_valid !== 1'b0 || btn_state[1] !== 1'b0) ok = 1'b0;
      end
    end
    check("bounce_rejected", 32'(ok), 32'd1);
    btn_raw[1] = 1'b1;
    get_msg("bounce", 8'h2F, 8'h7F);
    quiet("bounce_single", 20);

    // Simultaneous presses on btn 2 and btn 3.
    btn_raw[3:2] = 2'b11;
    get_msg("sim2", 8'h30, 8'h7F);
    step();
    check("sim_one_idle", 32'({msg_valid, msg_byte}), 32'({1'b1, 8'hB0}));
    get_msg("sim3", 8'h31, 8'h7F);
    quiet("sim_done", 20);

    // Overflow: consumer stalled while btn 0 toggles five times.
    msg_ready = 1'b0;
    drops = 0;
    for (int i = 0; i < 5; i++) begin
      btn_raw[0] = 1'b0;
      repeat (8) begin
        step();
        if (evt_drop === 1'b1) drops++;
      end
      btn_raw[0] = 1'b1;
      repeat (8) begin
        step();
        if (evt_drop === 1'b1) drops++;
      end
    end
    repeat (4) begin
      step();
      if (evt_drop === 1'b1) drops++;
    end
`ifdef MIDI_BTN_RELEASE_EN
    check("ovf_drops", 32'(drops), 32'd6);
`else
    check("ovf_drops", 32'(drops), 32'd1);
`endif
    check("ovf_stalled", 32'({msg_valid, msg_byte}), 32'({1'b1, 8'hB0}));
    msg_ready = 1'b1;
`ifdef MIDI_BTN_RELEASE_EN
    get_msg("ovf_a", 8'h2E, 8'h00);
    get_msg("ovf_b", 8'h2E, 8'h7F);
    get_msg("ovf_c", 8'h2E, 8'h00);
    get_msg("ovf_d", 8'h2E, 8'h7F);
`else
    get_msg("ovf_a", 8'h2E, 8'h7F);
    get_msg("ovf_b", 8'h2E, 8'h7F);
    get_msg("ovf_c", 8'h2E, 8'h7F);
    get_msg("ovf_d", 8'h2E, 8'h7F);
`endif
    quiet("ovf_no_extra", 20);

    // Reset in the middle of DATA1.
    btn_raw[1] = 1'b0;
`ifdef MIDI_BTN_RELEASE_EN
    get_msg("release1", 8'h2F, 8'h00);
`else
    quiet("release1_silent", 15);
`endif
    repeat (5) step();
    btn_raw[1] = 1'b1;
    wait_valid("rst_wait");
    step();
    check("rst_in_data1", 32'({msg_valid, msg_byte}), 32'({1'b1, 8'h2F}));
    #2;
    rst = 1'b0;
    #1;
    check("rst_async", 32'({msg_valid, msg_last, msg_byte}), 32'd0);
    btn_raw = '0;
    repeat (3) step();
    rst = 1'b1;
    quiet("rst_no_resume", 30);
    check("rst_btn_state", 32'(btn_state), 32'd0);
    btn_raw[2] = 1'b1;
    get_msg("post_rst", 8'h30, 8'h7F);
    check("post_rst_state", 32'(btn_state), 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_btn_event.md
# midi_btn_event

Upstream front-end for the MIDI transmitter. It synchronises and debounces NUM_BTN raw push-buttons and turns each qualified press (and optionally release) into a 3-byte MIDI Control Change message. Messages are queued in a small event FIFO and presented one byte at a time on a valid/ready byte stream that the UART framer consumes. All logic runs on the 100 MHz system clock; the framer owns baud timing.

## Interface
- NUM_BTN, 4: number of buttons; range 1–8.
- DEBOUNCE_CYC, 1_000_000: consecutive stable clk cycles required to accept a level change (10 ms at 100 MHz); minimum 2.
- FIFO_DEPTH, 4: event FIFO entries; power of two, minimum 2.
- CHANNEL, 4'h0: MIDI channel nibble.
- FIRST_CC, 8'd46: CC number for button 0; button i uses FIRST_CC+i; must be ≤ 127-NUM_BTN+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- btn_raw  in  NUM_BTN  raw buttons, asynchronous, active-high.
- msg_byte  out  8  current message byte.
- msg_valid  out  1  msg_byte is valid.
- msg_ready  in  1  consumer accepts the byte.
- msg_last  out  1  high with the third byte of a message.
- btn_state  out  NUM_BTN  debounced button levels.
- evt_drop  out  1  one-cycle pulse when an event is lost.

## Operation
- Sync: 2-flop synchroniser per button.
- Debounce (per button): counter clears whenever the synchronised level equals the stable level; otherwise it increments. When the counter reaches DEBOUNCE_CYC-1 while still mismatched, the stable level flips and the counter clears. A change on the cycle before acceptance restarts the count.
- Edge: a stable 0→1 flip is a press; 1→0 is a release (see Configuration).
- Pending latch (per button): an edge sets pending and records polarity. An edge on a button whose pending bit is already set overwrites the polarity and pulses evt_drop.
- Arbiter: when the FIFO is not full, the lowest-index pending button is pushed into the FIFO as {index, polarity} and its pending bit clears. At most one push per cycle.
- Serializer FSM:
  - IDLE: if the FIFO is non-empty, pop an entry into the hold register and go to STATUS.
  - STATUS: msg_byte={4'hB,CHANNEL}.
  - DATA1: msg_byte=FIRST_CC+index.
  - DATA2: msg_byte=8'h7F for a press, 8'h00 for a release; msg_last=1.
  - Each of STATUS, DATA1 and DATA2 advances only on msg_valid&&msg_ready. DATA2 returns to IDLE.
- No running status: every message carries its status byte.

## Timing
- Reset values: msg_valid=0, msg_last=0, msg_byte=0, evt_drop=0, btn_state=0, FSM=IDLE, FIFO empty, all pending bits and counters 0.
- Reset mid-message aborts the message immediately (asynchronous). No partial message is resumed.
- Latency: raw level first sampled at edge 0 → btn_state flips at edge 1+DEBOUNCE_CYC → pending set at edge 2+DEBOUNCE_CYC → FIFO write at edge 3+DEBOUNCE_CYC → msg_valid high after edge 4+DEBOUNCE_CYC. This assumes an idle FIFO and FSM.
- Handshake:
  - msg_byte and msg_last stay stable while msg_valid=1 and msg_ready=0.
  - msg_valid never drops without a transfer, except on reset.
  - Back-to-back messages: after DATA2 is accepted there is 1 IDLE cycle (msg_valid=0) before the next STATUS.
- FIFO full: the arbiter stalls and events wait in the pending latches. They are lost only by overwrite (evt_drop).
- FIFO push and pop in the same cycle are both legal. Occupancy is unchanged.

## Configuration
- MIDI_BTN_RELEASE_EN:
  - Defined: releases generate CC messages with value 8'h00.
  - Undefined: releases update btn_state only. They never set pending, never reach the FIFO and never cause evt_drop. The FIFO entry and hold register drop the polarity bit.

## Structure
- Package midi_pkg holds:
  - constants MIDI_CC_STATUS=4'hB, CC_ON=8'h7F, CC_OFF=8'h00;
  - typedef btn_evt_t {index, polarity};
  - enum ser_state_t {IDLE, STATUS, DATA1, DATA2}.
- Sub-module btn_debounce covers one button's synchroniser, counter and stable register. It is instantiated NUM_BTN times. The FIFO is inline.

## Test plan
All scenarios use DEBOUNCE_CYC=4 and msg_ready=1.
- Press btn 0: btn_raw[0] 0→1 held → bytes B0,2E,7F; msg_valid first high 8 edges after the first sampling edge; msg_last on 7F.
- Bounce: toggle btn_raw[1] every 2 cycles for 20 cycles, then hold 1 → exactly one message B0,2F,7F.
- Simultaneous: btn 2 and btn 3 press on the same cycle → B0,30,7F then B0,31,7F with 1 idle cycle between.
- Backpressure: msg_ready=0 for 10 cycles during DATA1 → msg_byte=2E held stable; sequence completes after ready returns.
- Overflow: FIFO_DEPTH=2, msg_ready=0; press/release btn 0 repeatedly → evt_drop pulses; after ready=1 no byte is duplicated or corrupted.
- Reset mid-DATA1 → msg_valid=0 immediately; after release of reset there is no output until a new press.
